// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizes for the FIFO write-side arbiter
package fifo_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 32;

  typedef enum bit [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } ARB_STATES;

  typedef enum bit {
    REQ_A_ID = 1'b0,
    REQ_B_ID = 1'b1
  } REQ_ID;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshakes and FIFO write-port bundle
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = fifo_arb_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = fifo_arb_pkg::DEFAULT_DEPTH
);
  logic                     REQ_A;
  logic [DATA_WIDTH-1:0]    DATA_A;
  logic                     ACK_A;
  logic                     REQ_B;
  logic [DATA_WIDTH-1:0]    DATA_B;
  logic                     ACK_B;
  logic                     FIFO_FULL;
  logic [$clog2(DEPTH)-1:0] FIFO_USE_DW;
  logic                     FIFO_WRITE;
  logic [DATA_WIDTH-1:0]    FIFO_DATA_IN;
  logic [1:0]               GRANT;

  // master: producers plus FIFO status; slave: the arbiter itself
  modport master (
    output REQ_A, DATA_A, REQ_B, DATA_B, FIFO_FULL, FIFO_USE_DW,
    input  ACK_A, ACK_B, FIFO_WRITE, FIFO_DATA_IN, GRANT
  );

  modport slave (
    input  REQ_A, DATA_A, REQ_B, DATA_B, FIFO_FULL, FIFO_USE_DW,
    output ACK_A, ACK_B, FIFO_WRITE, FIFO_DATA_IN, GRANT
  );
endinterface

// File: rtl/arb_burst_counter.sv
// rtl/arb_burst_counter.sv - counts accepted words in one ownership period
module arb_burst_counter #(
  parameter int BURST_MAX = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic INC,
  input  logic CLR,
  output logic DONE
);

  logic [3:0] cnt_q;

  // DONE flags the increment that lands on BURST_MAX so the owner releases on that ACK
  assign DONE = INC && (cnt_q == 4'(BURST_MAX - 1));

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      cnt_q <= 4'd0;
    end else if (INC) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port; optional FIFO_WR_ARB_STATS_EN adds ACK counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int BURST_MAX  = 4
) (
  input  logic CLK,
  input  logic RESET,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0] CNT_A,
  output logic [15:0] CNT_B
`endif
);

  localparam int USE_W = $clog2(DEPTH);

  ARB_STATES             state_q, state_d;
  REQ_ID                 last_q, last_d;
  logic                  ack_a, ack_b, inc, clr, done, space_ok;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] data_q;

  // A word registered last cycle lands in the FIFO on this edge, so 31 entries is already full
  assign space_ok = !bus.FIFO_FULL && !(wr_q && bus.FIFO_USE_DW == USE_W'(DEPTH - 1));
  assign inc      = ack_a || ack_b;

  arb_burst_counter #(.BURST_MAX(BURST_MAX)) u_burst (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (inc),
    .CLR   (clr),
    .DONE  (done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= REQ_B_ID;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ_A && (!bus.REQ_B || last_q == REQ_B_ID)) state_d = OWN_A;
        else if (bus.REQ_B)                                   state_d = OWN_B;
      end
      OWN_A: begin
        if (!bus.REQ_A || (ack_a && done)) begin
          clr     = 1'b1;
          last_d  = REQ_A_ID;
          state_d = bus.REQ_B ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (!bus.REQ_B || (ack_b && done)) begin
          clr     = 1'b1;
          last_d  = REQ_B_ID;
          state_d = bus.REQ_A ? OWN_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_a     = (state_q == OWN_A) && bus.REQ_A && space_ok;
    ack_b     = (state_q == OWN_B) && bus.REQ_B && space_ok;
    bus.GRANT = state_q;
  end

  assign bus.ACK_A = ack_a;
  assign bus.ACK_B = ack_b;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q   <= 1'b0;
      data_q <= '0;
    end else begin
      wr_q <= inc;
      if (ack_a)      data_q <= bus.DATA_A;
      else if (ack_b) data_q <= bus.DATA_B;
    end
  end

  assign bus.FIFO_WRITE   = wr_q;
  assign bus.FIFO_DATA_IN = data_q;

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CNT_A <= 16'd0;
      CNT_B <= 16'd0;
    end else begin
      if (ack_a && CNT_A != 16'hFFFF) CNT_A <= CNT_A + 16'd1;
      if (ack_b && CNT_B != 16'hFFFF) CNT_B <= CNT_B + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(8), .DEPTH(32)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(8), .DEPTH(32), .BURST_MAX(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .CNT_A (cnt_a),
    .CNT_B (cnt_b)
`endif
  );

  typedef struct {
    bit         rst, ra, rb, full;
    logic [7:0] da, db;
    logic [4:0] dw;
    bit         ea, eb, ew;
    logic [1:0] eg;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input bit rst_i, input bit ra, input logic [7:0] da,
                              input bit rb, input logic [7:0] db, input bit full,
                              input logic [4:0] dw, input bit ea, input bit eb,
                              input logic [1:0] eg, input bit ew, input logic [7:0] ed);
    vec_t v;
    v.rst = rst_i; v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.full = full; v.dw = dw;
    v.ea = ea; v.eb = eb; v.eg = eg; v.ew = ew; v.ed = ed;
    return v;
  endfunction

  task automatic drive(input bit r, input bit ra, input logic [7:0] da, input bit rb,
                       input logic [7:0] db, input bit full, input logic [4:0] dw);
    rst = r; bus.REQ_A = ra; bus.DATA_A = da; bus.REQ_B = rb; bus.DATA_B = db;
    bus.FIFO_FULL = full; bus.FIFO_USE_DW = dw;
  endtask

  task automatic check(input string name, input bit ea, input bit eb, input logic [1:0] eg,
                       input bit ew, input logic [7:0] ed);
    n_vec++;
    if (bus.ACK_A !== ea || bus.ACK_B !== eb || bus.GRANT !== eg ||
        bus.FIFO_WRITE !== ew || bus.FIFO_DATA_IN !== ed) begin
      n_bad++;
      $display("FAIL %s: got ack_a=%b ack_b=%b grant=%b wr=%b data=%h, want ack_a=%b ack_b=%b grant=%b wr=%b data=%h",
               name, bus.ACK_A, bus.ACK_B, bus.GRANT, bus.FIFO_WRITE, bus.FIFO_DATA_IN,
               ea, eb, eg, ew, ed);
    end
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic check_cnt(input string name, input logic [15:0] exp_a);
    n_vec++;
    if (cnt_a !== exp_a) begin
      n_bad++;
      $display("FAIL %s: got cnt_a=%0d, want %0d", name, cnt_a, exp_a);
    end
  endtask
`endif

  initial begin
    //           rst ra da     rb db     fl dw     ea eb eg     ew ed
    // A alone, four-word burst then back to IDLE
    tbl.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 5'd0, 0, 0, 2'b00, 0, 8'h00));
    tbl.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 5'd0, 1, 0, 2'b01, 0, 8'h00));
    tbl.push_back(mk(0, 1, 8'h12, 0, 8'h00, 0, 5'd0, 1, 0, 2'b01, 1, 8'h11));
    tbl.push_back(mk(0, 1, 8'h13, 0, 8'h00, 0, 5'd0, 1, 0, 2'b01, 1, 8'h12));
    tbl.push_back(mk(0, 1, 8'h14, 0, 8'h00, 0, 5'd0, 1, 0, 2'b01, 1, 8'h13));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 5'd0, 0, 0, 2'b00, 1, 8'h14));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 5'd0, 0, 0, 2'b00, 0, 8'h14));
    // reset, then both held: A x4, B x4, A with no idle gap
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 5'd0, 0, 0, 2'b00, 0, 8'h14));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 0, 0, 2'b00, 0, 8'h00));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 1, 0, 2'b01, 0, 8'h00));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 1, 0, 2'b01, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 1, 0, 2'b01, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 1, 0, 2'b01, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 0, 1, 2'b10, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 0, 1, 2'b10, 1, 8'hBB));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 0, 1, 2'b10, 1, 8'hBB));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 0, 1, 2'b10, 1, 8'hBB));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 8'hBB, 0, 5'd0, 1, 0, 2'b01, 1, 8'hBB));
    // reset, B served once and drops, then simultaneous requests: A wins
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 5'd0, 0, 0, 2'b01, 1, 8'hAA));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hB1, 0, 5'd0, 0, 0, 2'b00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hB1, 0, 5'd0, 0, 1, 2'b10, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 5'd0, 0, 0, 2'b10, 1, 8'hB1));
    tbl.push_back(mk(0, 1, 8'hA1, 1, 8'hB2, 0, 5'd0, 0, 0, 2'b00, 0, 8'hB1));
    tbl.push_back(mk(0, 1, 8'hA1, 1, 8'hB2, 0, 5'd0, 1, 0, 2'b01, 0, 8'hB1));
    // reset, B near-full stall (in-flight write), FULL stall, resume, burst held across stalls
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 5'd0, 0, 0, 2'b01, 1, 8'hA1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC1, 0, 5'd30, 0, 0, 2'b00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC1, 0, 5'd30, 0, 1, 2'b10, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC2, 0, 5'd31, 0, 0, 2'b10, 1, 8'hC1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC2, 1, 5'd31, 0, 0, 2'b10, 0, 8'hC1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC2, 0, 5'd31, 0, 1, 2'b10, 0, 8'hC1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC3, 0, 5'd0, 0, 1, 2'b10, 1, 8'hC2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC4, 0, 5'd0, 0, 1, 2'b10, 1, 8'hC3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC5, 0, 5'd0, 0, 0, 2'b00, 1, 8'hC4));

    drive(1, 0, 8'h00, 0, 8'h00, 0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset", 0, 0, 2'b00, 0, 8'h00);
`ifdef FIFO_WR_ARB_STATS_EN
    check_cnt("cnt_a_init", 16'd0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db, tbl[i].full, tbl[i].dw);
      #1 check($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eg, tbl[i].ew, tbl[i].ed);
    end

    // reset landing the cycle after an ACK discards the pending write
    @(negedge clk);
    drive(1, 0, 8'h00, 0, 8'h00, 0, 5'd0);
    @(negedge clk);
    drive(0, 1, 8'hD1, 0, 8'h00, 0, 5'd0);
    #1 check("midrst_idle", 0, 0, 2'b00, 0, 8'h00);
    @(negedge clk);
    #1 check("midrst_ack", 1, 0, 2'b01, 0, 8'h00);
    @(negedge clk);
    drive(1, 1, 8'hD2, 0, 8'h00, 0, 5'd0);
    #1 check("midrst_inflight", 1, 0, 2'b01, 1, 8'hD1);
`ifdef FIFO_WR_ARB_STATS_EN
    check_cnt("cnt_a_before_rst", 16'd1);
`endif
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 8'h00, 0, 5'd0);
    #1 check("midrst_after", 0, 0, 2'b00, 0, 8'h00);
`ifdef FIFO_WR_ARB_STATS_EN
    check_cnt("cnt_a_after_rst", 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
